// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: default datapath width and
// the controller state encoding.
package div_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/iter_div_if.sv
// Request/result bundle for the iterative divider.
// Optional macro DIV_SIGNED_EN adds the is_signed request bit.
interface iter_div_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic            is_signed;
`endif
    logic            busy;
    logic            done;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

`ifdef DIV_SIGNED_EN
    modport master (output start, dividend, divisor, is_signed,
                    input  busy, done, quotient, remainder);
    modport slave  (input  start, dividend, divisor, is_signed,
                    output busy, done, quotient, remainder);
`else
    modport master (output start, dividend, divisor,
                    input  busy, done, quotient, remainder);
    modport slave  (input  start, dividend, divisor,
                    output busy, done, quotient, remainder);
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next numerator bit,
// subtract the divisor when it fits. The compare is done one bit wider than
// the remainder so the shifted value never overflows.
module div_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            num_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          unused_bits;

    assign shifted = {rem_in, num_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = (shifted >= {1'b0, divisor});
    // The restored remainder is always below 2^XLEN, so the top bit is dead.
    assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign unused_bits = diff[XLEN] ^ shifted[XLEN];

endmodule

// File: rtl/iter_div.sv
// Iterative unsigned divider, BITS_PER_CYCLE quotient bits per clock, one
// operation in flight. Fixed latency: done after STEPS+1 edges from accept.
// Optional macro DIV_SIGNED_EN adds signed operation (magnitude divide with
// sign correction applied on the RUN->DONE edge).
module iter_div #(
    parameter int XLEN           = div_pkg::XLEN,
    parameter int BITS_PER_CYCLE = 2
) (
    input  logic      clock,
    input  logic      reset,
    iter_div_if.slave bus
);
    import div_pkg::*;

    localparam int STEPS = XLEN / BITS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS);

    generate
        if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2 && BITS_PER_CYCLE != 4) begin : g_bad_bpc
            $error("iter_div: BITS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    div_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic            last_q;
    logic            busy_q;
    logic            done_q;
    logic [XLEN-1:0] num_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] quotient_q;
    logic [XLEN-1:0] remainder_q;

    logic [XLEN-1:0] num_d;
    logic [XLEN-1:0] dvs_d;
    logic [XLEN-1:0] quo_fix_d;
    logic [XLEN-1:0] rem_fix_d;

`ifdef DIV_SIGNED_EN
    logic neg_n_q;
    logic neg_d_q;
    logic neg_n_d;
    logic neg_d_d;
`endif

    // Operand capture values: magnitudes when a signed divide is requested.
    always_comb begin
        num_d = bus.dividend;
        dvs_d = bus.divisor;
`ifdef DIV_SIGNED_EN
        neg_n_d = bus.is_signed & bus.dividend[XLEN-1];
        neg_d_d = bus.is_signed & bus.divisor[XLEN-1];
        if (neg_n_d) num_d = -bus.dividend;
        if (neg_d_d) dvs_d = -bus.divisor;
`endif
    end

    // Chained restoring steps, MSB of the remaining numerator first.
    logic [XLEN-1:0]           rem_chain [BITS_PER_CYCLE+1];
    logic [BITS_PER_CYCLE-1:0] q_bits;

    assign rem_chain[0] = rem_q;

    genvar gi;
    generate
        for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
            div_step #(.XLEN(XLEN)) u_step (
                .rem_in  (rem_chain[gi]),
                .num_bit (num_q[XLEN-1-gi]),
                .divisor (dvs_q),
                .rem_out (rem_chain[gi+1]),
                .q_bit   (q_bits[BITS_PER_CYCLE-1-gi])
            );
        end
    endgenerate

    // Final result; a zero divisor keeps the raw all-ones quotient.
    always_comb begin
        quo_fix_d = quo_q;
        rem_fix_d = rem_q;
`ifdef DIV_SIGNED_EN
        if ((neg_n_q ^ neg_d_q) && (dvs_q != '0)) quo_fix_d = -quo_q;
        if (neg_n_q) rem_fix_d = -rem_q;
`endif
    end

    // Controller and datapath registers; last_q marks that all steps are in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            num_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_SIGNED_EN
            neg_n_q     <= 1'b0;
            neg_d_q     <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        num_q   <= num_d;
                        dvs_q   <= dvs_d;
                        rem_q   <= '0;
                        quo_q   <= '0;
                        cnt_q   <= CNT_W'(STEPS - 1);
                        last_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_n_q <= neg_n_d;
                        neg_d_q <= neg_d_d;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (last_q) begin
                        quotient_q  <= quo_fix_d;
                        remainder_q <= rem_fix_d;
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        last_q      <= 1'b0;
                    end else begin
                        rem_q <= rem_chain[BITS_PER_CYCLE];
                        quo_q <= {quo_q[XLEN-1-BITS_PER_CYCLE:0], q_bits};
                        num_q <= num_q << BITS_PER_CYCLE;
                        if (cnt_q == '0) begin
                            last_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_iter_div.sv
// Self-checking bench for iter_div: directed cases plus a random unsigned
// regression, expectations queued at start and popped at done.
module tb_iter_div;

    localparam int W     = 64;
    parameter  int BPC   = 2;
    localparam int STEPS = W / BPC;
    localparam int LAT   = STEPS + 1;
    localparam int NRAND = 500;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    iter_div_if #(.XLEN(W)) bus ();

    iter_div #(.XLEN(W), .BITS_PER_CYCLE(BPC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] n;
        logic [63:0] d;
        logic        sgn;
        logic [63:0] q;
        logic [63:0] r;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Independent reference for unsigned divides.
    function automatic exp_t model_u(input logic [63:0] n, input logic [63:0] d);
        exp_t e;
        e.n = n; e.d = d; e.sgn = 1'b0;
        if (d == 64'd0) begin
            e.q = '1;
            e.r = n;
        end else begin
            e.q = n / d;
            e.r = n % d;
        end
        return e;
    endfunction

    // Present a request for one edge (called at posedge+1), then scramble operands.
    task automatic start_op(input logic [63:0] n, input logic [63:0] d, input logic sgn,
                            input bit accept, input logic [63:0] eq, input logic [63:0] er);
        exp_t e;
        bus.dividend = n;
        bus.divisor  = d;
`ifdef DIV_SIGNED_EN
        bus.is_signed = sgn;
`endif
        bus.start = 1'b1;
        @(posedge clock); #1;
        bus.start    = 1'b0;
        bus.dividend = {$urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
`ifdef DIV_SIGNED_EN
        bus.is_signed = $urandom_range(0, 1);
`endif
        if (accept) begin
            e.n = n; e.d = d; e.sgn = sgn; e.q = eq; e.r = er;
            sb.push_back(e);
        end
    endtask

    // Bounded wait for done; lat = edges counted from the current point.
    task automatic wait_done(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4 * LAT; i++) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL done_timeout: done not seen within %0d cycles", 4 * LAT);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.quotient !== 64'd0) $display("FAIL reset_q: got %h want 0", bus.quotient); else n_pass++;
        n_checks++; if (bus.remainder !== 64'd0) $display("FAIL reset_r: got %h want 0", bus.remainder); else n_pass++;
        $display("reset: busy=%b done=%b q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_basic();
        exp_t e; int lat; bit ok;
        start_op(64'd100, 64'd7, 1'b0, 1'b1, 64'd14, 64'd2);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL basic_busy_run: got %b want 1", bus.busy); else n_pass++;
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            n_checks++; if (lat != LAT) $display("FAIL basic_latency: got %0d want %0d", lat, LAT); else n_pass++;
            n_checks++; if (bus.quotient !== e.q) $display("FAIL basic_q: got %h want %h", bus.quotient, e.q); else n_pass++;
            n_checks++; if (bus.remainder !== e.r) $display("FAIL basic_r: got %h want %h", bus.remainder, e.r); else n_pass++;
            $display("basic: %0d / %0d -> q=%0d r=%0d lat=%0d", e.n, e.d, bus.quotient, bus.remainder, lat);
            @(posedge clock); #1;
            n_checks++; if (bus.done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", bus.done); else n_pass++;
            n_checks++; if (bus.busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", bus.busy); else n_pass++;
            n_checks++; if (bus.quotient !== e.q) $display("FAIL basic_q_hold: got %h want %h", bus.quotient, e.q); else n_pass++;
        end
    endtask

    task automatic test_extremes();
        exp_t e; int lat; bit ok;
        logic [63:0] tn [2];
        logic [63:0] td [2];
        logic [63:0] tq [2];
        logic [63:0] tr [2];
        tn[0] = 64'hFFFF_FFFF_FFFF_FFFF; td[0] = 64'd1;
        tq[0] = 64'hFFFF_FFFF_FFFF_FFFF; tr[0] = 64'd0;
        tn[1] = 64'd5;                   td[1] = 64'hFFFF_FFFF_FFFF_FFFF;
        tq[1] = 64'd0;                   tr[1] = 64'd5;
        for (int i = 0; i < 2; i++) begin
            start_op(tn[i], td[i], 1'b0, 1'b1, tq[i], tr[i]);
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                n_checks++; if (bus.quotient !== e.q) $display("FAIL extreme_q%0d: got %h want %h", i, bus.quotient, e.q); else n_pass++;
                n_checks++; if (bus.remainder !== e.r) $display("FAIL extreme_r%0d: got %h want %h", i, bus.remainder, e.r); else n_pass++;
                $display("extreme: %h / %h -> q=%h r=%h", e.n, e.d, bus.quotient, bus.remainder);
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e; int lat; bit ok;
        start_op(64'd1234, 64'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1234);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            n_checks++; if (lat != LAT) $display("FAIL divzero_latency: got %0d want %0d", lat, LAT); else n_pass++;
            n_checks++; if (bus.quotient !== e.q) $display("FAIL divzero_q: got %h want %h", bus.quotient, e.q); else n_pass++;
            n_checks++; if (bus.remainder !== e.r) $display("FAIL divzero_r: got %h want %h", bus.remainder, e.r); else n_pass++;
            $display("divzero: %0d / 0 -> q=%h r=%0d lat=%0d", e.n, bus.quotient, bus.remainder, lat);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; int lat; bit ok;
        start_op(64'd100, 64'd7, 1'b0, 1'b1, 64'd14, 64'd2);
        repeat (5) @(posedge clock);
        #1;
        // Request while busy: must be dropped.
        start_op(64'd10, 64'd3, 1'b0, 1'b0, 64'd0, 64'd0);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL ignore_busy: got %b want 1", bus.busy); else n_pass++;
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            n_checks++; if (lat != LAT - 6) $display("FAIL ignore_latency: got %0d want %0d", lat, LAT - 6); else n_pass++;
            n_checks++; if (bus.quotient !== e.q) $display("FAIL ignore_q: got %h want %h", bus.quotient, e.q); else n_pass++;
            n_checks++; if (bus.remainder !== e.r) $display("FAIL ignore_r: got %h want %h", bus.remainder, e.r); else n_pass++;
            $display("ignore: %0d / %0d -> q=%0d r=%0d", e.n, e.d, bus.quotient, bus.remainder);
        end
        // Now in the DONE cycle: start here is accepted immediately.
        start_op(64'd10, 64'd3, 1'b0, 1'b1, 64'd3, 64'd1);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.busy); else n_pass++;
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            n_checks++; if (lat != LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); else n_pass++;
            n_checks++; if (bus.quotient !== e.q) $display("FAIL b2b_q: got %h want %h", bus.quotient, e.q); else n_pass++;
            n_checks++; if (bus.remainder !== e.r) $display("FAIL b2b_r: got %h want %h", bus.remainder, e.r); else n_pass++;
            $display("b2b: %0d / %0d -> q=%0d r=%0d", e.n, e.d, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_async_reset();
        exp_t e; int lat; bit ok;
        start_op(64'd100, 64'd7, 1'b0, 1'b0, 64'd0, 64'd0);
        repeat (4) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL areset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL areset_done: got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.quotient !== 64'd0) $display("FAIL areset_q: got %h want 0", bus.quotient); else n_pass++;
        n_checks++; if (bus.remainder !== 64'd0) $display("FAIL areset_r: got %h want 0", bus.remainder); else n_pass++;
        $display("areset: busy=%b q=%h r=%h", bus.busy, bus.quotient, bus.remainder);
        repeat (2) @(posedge clock);
        @(negedge clock) reset = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL areset_idle: got %b want 0", bus.busy); else n_pass++;
        start_op(64'd9, 64'd4, 1'b0, 1'b1, 64'd2, 64'd1);
        wait_done(lat, ok);
        e = sb.pop_front();
        if (ok) begin
            n_checks++; if (bus.quotient !== e.q) $display("FAIL areset_after_q: got %h want %h", bus.quotient, e.q); else n_pass++;
            n_checks++; if (bus.remainder !== e.r) $display("FAIL areset_after_r: got %h want %h", bus.remainder, e.r); else n_pass++;
            $display("after reset: %0d / %0d -> q=%0d r=%0d", e.n, e.d, bus.quotient, bus.remainder);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        exp_t e; int lat; bit ok;
        logic [63:0] tn [4];
        logic [63:0] td [4];
        logic        ts [4];
        logic [63:0] tq [4];
        logic [63:0] tr [4];
        tn[0] = 64'hFFFF_FFFF_FFFF_FFF9; td[0] = 64'd2; ts[0] = 1'b1;
        tq[0] = 64'hFFFF_FFFF_FFFF_FFFD; tr[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        tn[1] = 64'h8000_0000_0000_0000; td[1] = 64'hFFFF_FFFF_FFFF_FFFF; ts[1] = 1'b1;
        tq[1] = 64'h8000_0000_0000_0000; tr[1] = 64'd0;
        tn[2] = 64'hFFFF_FFFF_FFFF_FFFB; td[2] = 64'd0; ts[2] = 1'b1;
        tq[2] = 64'hFFFF_FFFF_FFFF_FFFF; tr[2] = 64'hFFFF_FFFF_FFFF_FFFB;
        tn[3] = 64'hFFFF_FFFF_FFFF_FFFF; td[3] = 64'd2; ts[3] = 1'b0;
        tq[3] = 64'h7FFF_FFFF_FFFF_FFFF; tr[3] = 64'd1;
        for (int i = 0; i < 4; i++) begin
            start_op(tn[i], td[i], ts[i], 1'b1, tq[i], tr[i]);
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                n_checks++; if (bus.quotient !== e.q) $display("FAIL signed_q%0d: got %h want %h", i, bus.quotient, e.q); else n_pass++;
                n_checks++; if (bus.remainder !== e.r) $display("FAIL signed_r%0d: got %h want %h", i, bus.remainder, e.r); else n_pass++;
                $display("signed=%0b: %h / %h -> q=%h r=%h", e.sgn, e.n, e.d, bus.quotient, bus.remainder);
            end
        end
    endtask
`endif

    task automatic test_random();
        exp_t e; exp_t m; int lat; bit ok;
        logic [63:0] n, d;
        for (int k = 0; k < NRAND; k++) begin
            n = {$urandom, $urandom} >> $urandom_range(0, 40);
            case ($urandom_range(0, 4))
                0: d = {$urandom, $urandom};
                1: d = 64'($urandom_range(1, 1000));
                2: d = {32'd0, $urandom};
                3: d = n >> $urandom_range(0, 63);
                default: d = (k % 25 == 4) ? 64'd0 : ({$urandom, $urandom} >> $urandom_range(0, 63));
            endcase
            if (k % 5 == 0) begin
                repeat (2) begin
                    @(posedge clock); #1;
                end
            end
            m = model_u(n, d);
            start_op(n, d, 1'b0, 1'b1, m.q, m.r);
            wait_done(lat, ok);
            e = sb.pop_front();
            if (ok) begin
                n_checks++; if (bus.quotient !== e.q) $display("FAIL rand_q[%0d]: %h / %h got %h want %h", k, e.n, e.d, bus.quotient, e.q); else n_pass++;
                n_checks++; if (bus.remainder !== e.r) $display("FAIL rand_r[%0d]: %h / %h got %h want %h", k, e.n, e.d, bus.remainder, e.r); else n_pass++;
                $display("rand %0d: %h / %h -> q=%h r=%h", k, e.n, e.d, bus.quotient, bus.remainder);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_zero();
        test_back_to_back();
        test_async_reset();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
